uart_rx_8n1: RTL
================

Name: uart_rx_8n1

Overview:
- UART receiver for 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It is the counterpart of the existing uart_tx_8n1 transmitter.
- Runs directly on the board system clock (25 MHz). It times bits with an internal cycle counter, not a divided baud clock.
- Delivers each received byte through a valid/ready holding register. Reports framing errors and overruns as one-cycle pulses.
- Sits between the external RX pin and the byte-consuming logic in the top level, for example a loopback or pin-scan command parser.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- BAUDRATE, 9600, line bit rate in bit/s.
- CLKS_PER_BIT (local), CLK_FREQ/BAUDRATE with integer truncation. Must be >= 4; elaboration fails otherwise.
- HALF_BIT (local), CLKS_PER_BIT/2 with integer truncation.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rstn_i  input  1  asynchronous, active-low reset.
- rx_i  input  1  asynchronous serial input pin.
- data_o  output  8  received byte; stable while valid_o=1.
- valid_o  output  1  byte available in data_o.
- ready_i  input  1  consumer accepts data_o when valid_o&&ready_i.
- busy_o  output  1  high while a frame is in progress (state != IDLE).
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: an unconsumed byte was overwritten.

Behaviour:

Reset (rstn_i=0, async):
- Synchronizer flops = 1, state=IDLE, counters=0, shift register=0.
- data_o=0x00, valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0.

Input synchronization:
- rx_i passes through 2 flops to give rx_s, so rx_s lags rx_i by 2 cycles.
- All decisions use rx_s only.

Counters:
- cnt is a bit-timing counter, wide enough for CLKS_PER_BIT-1.
- bit_idx is 3 bits.

FSM:
- IDLE: when rx_s=0, go to START with cnt=0.
- START: cnt increments each cycle. When cnt==HALF_BIT-1:
  - rx_s=0: go to DATA, cnt=0, bit_idx=0.
  - rx_s=1: glitch; go to IDLE with no flag and no output change.
- DATA: cnt increments. When cnt==CLKS_PER_BIT-1:
  - Shift rx_s into the shift register MSB and shift right (LSB-first reception), set cnt=0.
  - If bit_idx==7, go to STOP; otherwise bit_idx+1.
- STOP: when cnt==CLKS_PER_BIT-1:
  - rx_s=1: load data_o from the shift register, set valid_o=1, go to IDLE.
  - rx_s=0: pulse frame_err_o, leave data_o and valid_o unchanged, go to WAIT_IDLE.
- WAIT_IDLE (break or garbage line): stay until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering frames.

Sampling:
- Each data and stop bit is sampled at its nominal mid-point, relative to the rx_i edge: bit n at 24+16n cycles after the start edge when CLKS_PER_BIT=16.

Handshake:
- valid_o stays 1 until a cycle with ready_i=1, then clears on the next edge.
- ready_i is ignored while valid_o=0.
- If a byte completes in the same cycle as valid_o&&ready_i: the old byte is consumed, data_o loads the new byte, valid_o stays 1, and there is no overrun.
- If a byte completes while valid_o=1 and ready_i=0: data_o is overwritten with the new byte, valid_o stays 1, and overrun_o pulses for 1 cycle.

Other rules:
- Flags are registered, one cycle wide, never sticky.
- Back-to-back frames: a new start bit may be detected in the cycle immediately after STOP returns to IDLE.
- Reset mid-frame aborts immediately. After release, the receiver waits in IDLE; if rx_i is low at release, a new START attempt begins, which is acceptable.

Test Plan (CLK_FREQ=160, BAUDRATE=10, so CLKS_PER_BIT=16):
1. Frame 0x55 driven on rx_i with 16-cycle bits -> valid_o rises exactly 155 cycles after the cycle rx_i falls; data_o=0x55; frame_err_o=0; overrun_o=0; busy_o high throughout the frame.
2. Frames 0xA3 then 0x0F back-to-back with no idle gap, ready_i held 1 -> two valid_o assertions with data_o=0xA3 then 0x0F; no flags.
3. rx_i low for 5 cycles then high -> returns to IDLE; no valid_o, no frame_err_o; busy_o high for at most 8 cycles.
4. Frame 0x81 with stop bit low, then line held low 40 cycles -> frame_err_o pulses once; valid_o stays 0; no new frame starts until rx_i returns high.
5. ready_i=0, send 0x12 then 0x34 -> first valid_o=1 with data_o=0x12; at completion of the second frame overrun_o pulses 1 cycle and data_o=0x34. Then raise ready_i -> valid_o clears the following cycle.
6. rstn_i pulsed low mid-way through DATA of a frame 0xFF -> all outputs return to reset values asynchronously; a subsequent clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver timed by a system-clock cycle counter, with a valid/ready
// holding register and one-cycle framing-error and overrun pulses.
module uart_rx_8n1 #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUDRATE = 9600
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_param_check
    $error("uart_rx_8n1: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             byte_done;

  always_comb begin
    sync1_d     = rx_i;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      // A start bit still low at its centre is genuine; otherwise treat it as a glitch.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new byte wins over a same-cycle consume; it only overruns if the old one was not taken.
    if (byte_done) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      overrun_d = valid_q && !ready_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
